// File: rtl/digit_entry_ctrl.sv
// Digit entry controller: debounced key press writes sw_data to the next display digit, clr
// blanks all eight digits. Define DIGIT_ENTRY_WRAP_EN to let entries overwrite when full.
module digit_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter logic [3:0]  CLR_VAL         = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       clr,
    input  logic [3:0] sw_data,
    output logic [3:0] data_out,
    output logic [2:0] sel_out,
    output logic       wr_en,
    output logic       scan_tick,
    output logic       busy,
    output logic       full
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    state_e         state_q;
    logic           key_s1_q, key_s2_q, key_deb_q, key_deb_prev_q;
    logic [DbW-1:0] db_cnt_q;
    logic           clr_s1_q, clr_s2_q, clr_s3_q;
    logic [2:0]     ptr_q;
    logic [3:0]     count_q;
    logic [2:0]     clr_idx_q;
    logic [DivW-1:0] div_q;

    logic press;
    logic clr_rise;
    logic write_ok;

    assign press    = key_deb_prev_q & ~key_deb_q;
    assign clr_rise = clr_s2_q & ~clr_s3_q;

`ifdef DIGIT_ENTRY_WRAP_EN
    assign write_ok = 1'b1;
`else
    assign write_ok = ~full;
`endif

    // Key synchronizer and debounce; the count restarts on any cycle without a mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1_q       <= 1'b1;
            key_s2_q       <= 1'b1;
            key_deb_q      <= 1'b1;
            key_deb_prev_q <= 1'b1;
            db_cnt_q       <= '0;
        end else begin
            key_s1_q       <= key_n;
            key_s2_q       <= key_s1_q;
            key_deb_prev_q <= key_deb_q;
            if (key_s2_q != key_deb_q) begin
                if (db_cnt_q == DbLast) begin
                    key_deb_q <= key_s2_q;
                    db_cnt_q  <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            clr_s3_q <= 1'b0;
        end else begin
            clr_s1_q <= clr;
            clr_s2_q <= clr_s1_q;
            clr_s3_q <= clr_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            scan_tick <= 1'b0;
        end else if (div_q == DivLast) begin
            div_q     <= '0;
            scan_tick <= 1'b1;
        end else begin
            div_q     <= div_q + 1'b1;
            scan_tick <= 1'b0;
        end
    end

    // Clear takes priority over a press detected in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            data_out  <= 4'h0;
            sel_out   <= 3'd0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            full      <= 1'b0;
            ptr_q     <= 3'd0;
            count_q   <= 4'd0;
            clr_idx_q <= 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_rise) begin
                        state_q   <= StClear;
                        wr_en     <= 1'b1;
                        busy      <= 1'b1;
                        sel_out   <= 3'd0;
                        data_out  <= CLR_VAL;
                        clr_idx_q <= 3'd0;
                    end else if (press && write_ok) begin
                        state_q  <= StWrite;
                        wr_en    <= 1'b1;
                        sel_out  <= ptr_q;
                        data_out <= sw_data;
                        ptr_q    <= ptr_q + 3'd1;
                        if (count_q != 4'd8) begin
                            count_q <= count_q + 4'd1;
                        end
                        full <= (count_q >= 4'd7);
                    end
                end
                StWrite: begin
                    state_q <= StIdle;
                    wr_en   <= 1'b0;
                end
                StClear: begin
                    if (clr_idx_q == 3'd7) begin
                        state_q <= StIdle;
                        wr_en   <= 1'b0;
                        busy    <= 1'b0;
                        ptr_q   <= 3'd0;
                        count_q <= 4'd0;
                        full    <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 3'd1;
                        sel_out   <= clr_idx_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    wr_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Self-checking bench for digit_entry_ctrl with DEBOUNCE_CYCLES=4, SCAN_DIV=5, CLR_VAL=F.
module tb_digit_entry_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 5;
    localparam logic [3:0]  CV = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic       clr;
    logic [3:0] sw_data;
    logic [3:0] data_out;
    logic [2:0] sel_out;
    logic       wr_en;
    logic       scan_tick;
    logic       busy;
    logic       full;

    int checks = 0;
    int failures = 0;
    logic [6:0] sb[$];
    logic [6:0] exp_w;

    digit_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SCAN_DIV(S),
        .CLR_VAL(CV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .clr(clr),
        .sw_data(sw_data),
        .data_out(data_out),
        .sel_out(sel_out),
        .wr_en(wr_en),
        .scan_tick(scan_tick),
        .busy(busy),
        .full(full)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got sel=%0d data=%h, expected no write",
                         sel_out, data_out);
            end else begin
                exp_w = sb.pop_front();
                if ({sel_out, data_out} !== exp_w) begin
                    failures++;
                    $display("FAIL write_content: got sel=%0d data=%h, expected sel=%0d data=%h",
                             sel_out, data_out, exp_w[6:4], exp_w[3:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; key_n = 1'b1; clr = 1'b0; sw_data = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data_out, sel_out, wr_en, scan_tick, busy, full} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {data_out, sel_out, wr_en, scan_tick, busy, full});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (scan_tick !== ((e % S) == 0)) begin
                failures++;
                $display("FAIL scan_tick_edge%0d: got %b, expected %b", e, scan_tick,
                         ((e % S) == 0));
            end
        end
    endtask

    // Hold key low from a negedge, find the first wr_en edge, then release.
    task automatic do_press(input logic [3:0] d, input bit exp_wr, input logic [2:0] exp_sel,
                            input string name);
        int seen;
        int exp_edge;
        seen = 0;
        exp_edge = exp_wr ? int'(D + 3) : 0;
        if (exp_wr) sb.push_back({exp_sel, d});
        @(negedge clk);
        sw_data = d;
        key_n = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1 && seen == 0) seen = e;
        end
        checks++;
        if (seen != exp_edge) begin
            failures++;
            $display("FAIL %s_edge: got first wr_en edge %0d, expected %0d", name, seen, exp_edge);
        end
        @(negedge clk);
        key_n = 1'b1;
        repeat (D + 7) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_pending: got %0d writes outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_clean_press();
        do_press(4'h9, 1'b1, 3'd0, "clean_press");
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        sb.push_back({3'd1, 4'h4});
        @(negedge clk);
        sw_data = 4'h4;
        for (int b = 0; b < 5; b++) begin
            key_n = 1'b0;
            repeat (2) @(negedge clk);
            key_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        key_n = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1 && seen == 0) seen = e;
        end
        checks++;
        if (seen != int'(D + 3)) begin
            failures++;
            $display("FAIL bounce_edge: got first wr_en edge %0d, expected %0d", seen, D + 3);
        end
        @(negedge clk);
        key_n = 1'b1;
        repeat (D + 7) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bounce_pending: got %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Clear sequence, with a second clr rising edge injected mid-sequence that must be ignored.
    task automatic test_clear();
        int first;
        first = 0;
        for (int i = 0; i < 8; i++) sb.push_back({3'(i), CV});
        @(negedge clk);
        clr = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1) begin
                first = e;
                break;
            end
        end
        checks++;
        if (first != 3) begin
            failures++;
            $display("FAIL clear_start: got first wr_en edge %0d, expected 3", first);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || wr_en !== 1'b1) begin
                failures++;
                $display("FAIL clear_cycle%0d: got busy=%b wr_en=%b, expected 1 1", i, busy, wr_en);
            end
            @(negedge clk);
            if (i == 1) clr = 1'b0;
            if (i == 3) clr = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if ({wr_en, busy, full} !== 3'b000) begin
            failures++;
            $display("FAIL clear_exit: got wr_en/busy/full=%b, expected 000", {wr_en, busy, full});
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL clear_pending: got %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            do_press(4'(i), 1'b1, 3'(i - 1), "fill");
            if (i == 7) begin
                checks++;
                if (full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_after7: got %b, expected 0", full);
                end
            end
        end
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_after8: got %b, expected 1", full);
        end
`ifdef DIGIT_ENTRY_WRAP_EN
        do_press(4'h9, 1'b1, 3'd0, "ninth_wrap");
`else
        do_press(4'h9, 1'b0, 3'd0, "ninth_ignored");
`endif
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_after9: got %b, expected 1", full);
        end
    endtask

    // Press detect and clr rising edge land in the same idle cycle: clear must win.
    task automatic test_simultaneous();
        int first;
        first = 0;
        for (int i = 0; i < 8; i++) sb.push_back({3'(i), CV});
        @(negedge clk);
        sw_data = 4'h7;
        key_n = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1 && first == 0) first = e;
            if (e == 4) clr = 1'b1;
        end
        checks++;
        if (first != int'(D + 3)) begin
            failures++;
            $display("FAIL simul_start: got first wr_en edge %0d, expected %0d", first, D + 3);
        end
        @(negedge clk);
        key_n = 1'b1;
        clr = 1'b0;
        repeat (D + 7) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simul_pending: got %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
        do_press(4'h6, 1'b1, 3'd0, "after_simul");
    endtask

    task automatic test_reset_mid_clear();
        int first;
        first = 0;
        for (int i = 0; i < 3; i++) sb.push_back({3'(i), CV});
        @(negedge clk);
        clr = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (wr_en === 1'b1) begin
                first = e;
                break;
            end
        end
        checks++;
        if (first != 3) begin
            failures++;
            $display("FAIL rstclr_start: got first wr_en edge %0d, expected 3", first);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({data_out, sel_out, wr_en, scan_tick, busy, full} !== 11'd0) begin
            failures++;
            $display("FAIL rstclr_outputs: got %b, expected all zero",
                     {data_out, sel_out, wr_en, scan_tick, busy, full});
        end
        clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wr_en !== 1'b0) begin
                failures++;
                $display("FAIL rstclr_hold%0d: got wr_en=%b, expected 0", c, wr_en);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rstclr_pending: got %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_clear();
        test_fill();
        test_clear();
        do_press(4'h3, 1'b1, 3'd0, "pre_simul");
        test_simultaneous();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_entry_ctrl.md
DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, means consecutive stable cycles needed to accept a key level change; range ≥1.
REQ-002 Parameter SCAN_DIV, default 50000, means clk cycles per scan_tick; range ≥2.
REQ-003 Parameter CLR_VAL, default 4'h0, means the digit value written to all positions on clear.
REQ-004 Port clk, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit, is the reset: synchronous, active-high.
REQ-006 Port key_n, input, 1 bit, is the raw asynchronous entry push button, active-low and bouncy.
REQ-007 Port clr, input, 1 bit, is the raw asynchronous clear switch, active-high.
REQ-008 Port sw_data, input, 4 bits, is the digit value from the switches.
REQ-009 Port data_out, output, 4 bits, is the value to write; it drives the display latch data.
REQ-010 Port sel_out, output, 3 bits, is the target digit index; it drives the display latch select.
REQ-011 Port wr_en, output, 1 bit, is a one-cycle write strobe; it drives the display latch enable.
REQ-012 Port scan_tick, output, 1 bit, is a one-cycle pulse that advances the display scan counter.
REQ-013 Port busy, output, 1 bit, is high while the clear sequence runs.
REQ-014 Port full, output, 1 bit, is high once 8 digits have been entered since the last clear or reset.

Function
REQ-015 key_n and clr SHALL each pass through a 2-flop synchronizer before any use.
- Debounce: the debounced key level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch-free cycle SHALL reset the debounce count.
REQ-016 A press event SHALL be a debounced 1->0 transition; release SHALL generate no event.
REQ-017 FSM states SHALL be IDLE, WRITE and CLEAR.
- IDLE->WRITE on a press event when writing is allowed; WRITE->IDLE after 1 cycle.
- IDLE->CLEAR on a synchronized clr rising edge; CLEAR->IDLE after 8 cycles.
REQ-018 WRITE: wr_en SHALL be 1 for exactly one cycle, with sel_out=ptr and data_out=sw_data sampled at the press-detect edge.
- After the write: ptr increments; count saturates at 8.
REQ-019 Timing: with key_n held low, wr_en SHALL rise on rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_n low as edge 1.
REQ-020 CLEAR: wr_en SHALL be 1 for 8 consecutive cycles, with sel_out stepping 0..7 and data_out=CLR_VAL.
- busy SHALL be 1 throughout CLEAR.
- On exit: ptr=0, count=0, full=0.
REQ-021 Press events during CLEAR or WRITE SHALL be discarded, not queued.
REQ-022 A clr rising edge during CLEAR SHALL be ignored; the sequence does not restart.
REQ-023 If a press event and a clr rising edge occur in the same IDLE cycle, clear wins and no digit write occurs.
REQ-024 Outside WRITE and CLEAR, wr_en SHALL be 0, and data_out and sel_out SHALL hold their last values.
REQ-025 scan_tick SHALL free-run: 1 when the divider equals SCAN_DIV-1, then the divider returns to 0.
- The first tick SHALL come SCAN_DIV edges after reset release.
- scan_tick SHALL be unaffected by clear and key activity.

Reset
REQ-026 While rst=1 at a clock edge, the following SHALL be set:
- Outputs: data_out=0, sel_out=0, wr_en=0, scan_tick=0, busy=0, full=0.
- Internal state: ptr=0, count=0, divider=0, FSM=IDLE.
- Debounce: debounced key=1 (released), debounce count=0, synchronizers=idle levels.
REQ-027 Reset asserted mid-CLEAR or mid-WRITE SHALL abort the sequence immediately, with no further wr_en.

Configuration
REQ-028 Macro DIGIT_ENTRY_WRAP_EN selects full-buffer behaviour.
- Defined: a press with full=1 writes at ptr, ptr wraps 7->0, and full stays 1 (oldest digit overwritten).
- Undefined: a press with full=1 is ignored, with no wr_en and ptr unchanged.

Verification (DEBOUNCE_CYCLES=4, SCAN_DIV=5)
REQ-029 Clean press, sw_data=4'h9, ptr=0 -> one wr_en pulse at edge 7, sel_out=0, data_out=9; then ptr=1.
REQ-030 Press bouncing low/high every 2 cycles for 20 cycles, then held low -> exactly one wr_en, edge 7 counted from the final stable low.
REQ-031 9 presses with sw_data 1..9 -> writes to sel 0..7, full=1 after the 8th.
- 9th press without macro: no wr_en.
- 9th press with macro: write sel_out=0, data_out=9.
REQ-032 clr rising edge with CLR_VAL=4'hF -> busy=1 and wr_en=1 for 8 cycles, sel_out 0..7, data_out=F; then full=0 and the next press writes sel_out=0.
REQ-033 Press detect and clr edge in the same cycle -> only the clear sequence runs; after it, a new press writes sel_out=0.
REQ-034 Reset release -> scan_tick high on edges 5, 10, 15.
- rst asserted during the 3rd clear cycle -> wr_en=0 from the next edge, all outputs at reset values.
